// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding and default sizing constants.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 8;
    localparam int BUS_W        = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit scanning ptr+1, ptr+2, ... modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int OW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    ptr,
    output logic             valid,
    output logic [OW-1:0]    sel
);

    logic [OW-1:0] idx;

    always_comb begin
        valid = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = OW'((int'(ptr) + i) % N_REQ);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                sel   = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared tri-state data bus, with a hold
// timeout and one turnaround cycle between owners.
//
// state   | meaning
// IDLE    | bus free, arbitrate among pending requests
// GRANT   | one requester owns the bus, hold counter running
// RELEASE | turnaround cycle, no driver enabled, requests ignored
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int OW       = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [OW-1:0]    owner,
    output logic             busy,
    output logic             timeout
);

    localparam int            CW        = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [OW-1:0] PTR_RST   = OW'(N_REQ - 1);

    state_t            state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_d;
    logic [OW-1:0]     owner_d;
    logic              busy_d;
    logic              timeout_d;

    logic              pick_valid;
    logic [OW-1:0]     pick_sel;
    logic              own_done;
    logic              own_req;
    logic              expire;

    rr_pick #(
        .N_REQ (N_REQ),
        .OW    (OW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    assign own_done = done[owner];
    assign own_req  = req[owner];
    assign expire   = (cnt_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            cnt_q   <= '0;
            gnt     <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            owner   <= owner_d;
            busy    <= busy_d;
            timeout <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt;
        owner_d   = owner;
        busy_d    = busy;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_sel] = 1'b1;
                    owner_d         = pick_sel;
                    busy_d          = 1'b1;
                    cnt_d           = '0;
                    state_d         = GRANT;
                end
            end

            GRANT: begin
                cnt_d = cnt_q + 1'b1;
                if (own_done || !own_req || expire) begin
                    // A completion or withdrawal in the expiry cycle wins over the timeout.
                    timeout_d = expire && !own_done && own_req;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = owner;
                    cnt_d     = '0;
                    state_d   = RELEASE;
                end
            end

            RELEASE: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized
// run, all compared cycle by cycle against an ownership/cooldown model.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       RST;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // Model: who holds the bus, for how many cycles so far, turnaround edges left,
    // and who was served last.
    int         m_holder = -1;
    int         m_held   = 0;
    int         m_cool   = 0;
    int         m_last   = N - 1;
    int         m_owner  = 0;
    logic [3:0] m_gnt    = 4'b0;
    logic       m_busy   = 1'b0;
    logic       m_timeout = 1'b0;
    logic [3:0] prev_gnt = 4'b0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk     (clk),
        .RST     (RST),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        m_timeout = 1'b0;
        if (RST) begin
            m_holder = -1;
            m_held   = 0;
            m_cool   = 0;
            m_last   = N - 1;
            m_owner  = 0;
        end else if (m_holder >= 0) begin
            if (done[m_holder] || !req[m_holder] || m_held == MH) begin
                m_timeout = (m_held == MH) && !done[m_holder] && req[m_holder];
                m_last    = m_holder;
                m_holder  = -1;
                m_cool    = 1;
            end else begin
                m_held++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_holder < 0 && req[c]) begin
                    m_holder = c;
                    m_owner  = c;
                    m_held   = 1;
                end
            end
        end
        m_gnt  = (m_holder >= 0) ? 4'(1 << m_holder) : 4'b0;
        m_busy = (m_holder >= 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("timeout", 32'(timeout), 32'(m_timeout));
        checks++;
        assert ($onehot0(gnt) && !(prev_gnt != 4'b0 && gnt != 4'b0 && gnt != prev_gnt))
        else begin
            errors++;
            $error("FAIL gnt_handover observed=%b previous=%b expected one-hot with idle gap", gnt, prev_gnt);
        end
        prev_gnt = gnt;
    endtask

    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (gnt == 4'b0 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(gnt != 4'b0), 32'd1);
    endtask

    task automatic count_idle(input string tag);
        int zeros;
        int n;
        zeros = 0;
        n     = 0;
        while (gnt == 4'b0 && n < 20) begin
            zeros++;
            tick();
            n++;
        end
        chk(tag, 32'(zeros), 32'd2);
    endtask

    initial begin
        int order[5];
        int exp_order[5];
        int hi;
        int n;

        exp_order = '{0, 1, 2, 3, 0};
        RST  = 1'b1;
        req  = 4'b0;
        done = 4'b0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);

        // Single requester with completion strobe.
        RST = 1'b0;
        req = 4'b0001;
        tick();
        chk("single_gnt", 32'(gnt), 32'h1);
        tick();
        tick();
        done = 4'b0001;
        tick();
        done = 4'b0;
        req  = 4'b0;
        chk("single_rel", 32'(gnt), 32'h0);
        chk("single_owner", 32'(owner), 32'd0);
        repeat (3) tick();

        // All requesting after reset: rotation order and turnaround gaps.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant("rr_wait");
            order[g] = int'(owner);
            tick();
            done = gnt;
            tick();
            done = 4'b0;
            if (g < 4) count_idle("rr_gap");
        end
        req = 4'b0;
        for (int g = 0; g < 5; g++) chk("rr_order", 32'(order[g]), 32'(exp_order[g]));
        repeat (3) tick();

        // Hold timeout with no completion.
        req = 4'b0100;
        wait_grant("to_wait");
        hi = 0;
        n  = 0;
        while (gnt != 4'b0 && n < 20) begin
            hi++;
            tick();
            n++;
        end
        chk("to_len", 32'(hi), 32'd8);
        chk("to_pulse", 32'(timeout), 32'd1);
        count_idle("to_gap");
        chk("to_regrant", 32'(gnt), 32'h4);

        // Completion in the expiry cycle counts as normal release.
        repeat (7) tick();
        done = 4'b0100;
        tick();
        done = 4'b0;
        chk("exp_done_gnt", 32'(gnt), 32'h0);
        chk("exp_done_to", 32'(timeout), 32'd0);
        req = 4'b0;
        repeat (3) tick();

        // Stray done from a non-owner, then withdrawal.
        req = 4'b0010;
        wait_grant("wd_wait");
        chk("wd_owner", 32'(owner), 32'd1);
        tick();
        done = 4'b1000;
        tick();
        done = 4'b0;
        chk("stray_done", 32'(gnt), 32'h2);
        req = 4'b0;
        tick();
        chk("withdraw", 32'(gnt), 32'h0);
        repeat (3) tick();

        // Reset in the middle of a grant.
        req = 4'b0100;
        wait_grant("rst_wait");
        tick();
        chk("rst_owner", 32'(owner), 32'd2);
        RST = 1'b1;
        tick();
        chk("rst_mid_gnt", 32'(gnt), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_to", 32'(timeout), 32'd0);
        RST = 1'b0;
        req = 4'b1111;
        tick();
        chk("rst_first", 32'(gnt), 32'h1);
        req = 4'b0;
        repeat (4) tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
            RST  = ($urandom_range(0, 80) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single 16-bit data bus between the requesters (cores and register-transfer units). Those requesters drive the bus through tri-state LDBUS-style enables. The arbiter grants exactly one requester at a time and holds the grant until that requester signals completion or a hold timeout expires. It also inserts one idle turnaround cycle between owners so two tri-state drivers never overlap.

## Interface
- N_REQ, 4, number of requesters (2..8)
- MAX_HOLD, 8, maximum grant length in cycles before forced release (≥2)
- OW, $clog2(N_REQ), width of the owner index
- clk  input  1  system clock, all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- req  input  N_REQ  per-requester bus request, level, held until served
- done  input  N_REQ  per-requester completion strobe, one cycle, only meaningful from the current owner
- gnt  output  N_REQ  registered one-hot grant; requester i may assert its LDBUS/WR only while gnt[i]=1
- owner  output  OW  index of current/last owner
- busy  output  1  high while any grant is active
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry

## Operation
- States: IDLE, GRANT, RELEASE.
- Reset values:
  - gnt=0, owner=0, busy=0, timeout=0, state=IDLE
  - round-robin pointer ptr=N_REQ-1, so requester 0 has first priority
  - hold counter=0
- IDLE:
  - if any req bit is set, select the first set bit scanning ptr+1, ptr+2, … modulo N_REQ
  - next cycle: gnt=one-hot(sel), owner=sel, busy=1, counter=0, state=GRANT
  - if no request, remain in IDLE with all outputs 0 except owner, which holds its last value
- GRANT: counter increments every cycle. Release occurs on the first of the following:
  - done[owner]=1, or
  - req[owner]=0 (requester withdrew), or
  - counter==MAX_HOLD-1, which sets timeout=1 for exactly one cycle
- On release: gnt=0, busy=0, ptr=owner, state=RELEASE.
- Simultaneous done[owner] and counter expiry: treated as a normal completion, timeout stays 0.
- done from any non-owner is ignored in every state. done in IDLE or RELEASE is ignored.
- RELEASE: bus turnaround, all gnt low for one cycle, then IDLE. Requests are not sampled in RELEASE.
- req changes during GRANT never move the grant. Only release moves it.
- RST asserted mid-grant: gnt drops on the next edge, no timeout pulse, ptr returns to N_REQ-1.
- Invariant: gnt is zero or one-hot. No cycle has gnt changing directly from one owner to another.

## Timing
- Arbitration latency: req sampled high in IDLE at edge t, so gnt high after edge t+1. One cycle of latency.
- Completion: done sampled at edge t, so gnt low after t+1. Then RELEASE for one cycle, IDLE at t+2, and the next grant is visible at t+3 at the earliest.
- Minimum gap between two grants is 2 cycles with gnt=0.
- Maximum grant length is MAX_HOLD cycles.
- Worst-case wait for a continuously requesting unit is (N_REQ-1)·(MAX_HOLD+2)+1 cycles.
- All outputs are registered. No combinational path from req or done to gnt.

## Structure
- Shared package bus_pkg:
  - state enum {IDLE, GRANT, RELEASE}
  - default constants N_REQ_DEF=4, MAX_HOLD_DEF=8, BUS_W=16 (the last one is shared with the register blocks)
- Sub-module rr_pick: combinational rotate-priority encoder.
  - inputs req and ptr
  - outputs valid and sel index
  - reused by any future memory-port arbiter
- Top contains the FSM, hold counter, ptr register and output registers.

## Test plan
- Single request, N_REQ=4, MAX_HOLD=8, after reset:
  - stimulus: req=0001, done[0] strobed 3 cycles after grant
  - required response: gnt=0001 one cycle after req; gnt=0000 after done; owner=0; timeout never set
- All request, req=1111 held, each owner strobes done after 2 cycles:
  - required grant order: 0,1,2,3,0
  - each grant is separated by exactly 2 cycles of gnt=0000
- Timeout, req=0100 held, no done:
  - gnt[2] is high for exactly 8 cycles
  - timeout pulses in the cycle gnt drops
  - gnt[2] is re-granted 3 cycles later
- Done coinciding with expiry: done[owner] in counter cycle 7 → release occurs with timeout=0.
- Withdrawal and stray done:
  - owner 1 drops req mid-grant → release next cycle
  - done[3] while owner is 1 → ignored, gnt unchanged
- Reset mid-grant: RST during GRANT with owner=2 → gnt=0, busy=0, timeout=0 next cycle; the next req=1111 grants requester 0.
